// File: rtl/out_port_buffer.sv
// Output-port FIFO for a NoC router lane: buffers crossbar flits, tracks packet
// framing so the switch allocator can hold the port, and flags drops.
module out_port_buffer #(
    parameter int Flit_size = 16,
    parameter int Depth     = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [Flit_size-1:0]         In_data,
    input  logic                         In_valid,
    output logic [Flit_size-1:0]         Out_data,
    output logic                         Out_valid,
    input  logic                         Out_ready,
    output logic [$clog2(Depth+1)-1:0]   Credit,
    output logic                         Full,
    output logic                         Port_busy,
    output logic                         Ovf_err,
    output logic                         Proto_err
);

    localparam int PW = $clog2(Depth);
    localparam int CW = $clog2(Depth + 1);

    typedef enum logic [1:0] {
        FT_HEAD   = 2'b00,
        FT_BODY   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_t;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    // Handshake: a flit leaves when Out_valid && Out_ready at a rising CLK edge;
    // the upstream side has no back-pressure, so In_valid is a one-cycle strobe.

    state_t                 state_q;
    state_t                 state_d;
    flit_type_t             flit_type;
    logic                   fsm_accept;
    logic                   pop;
    logic                   space_ok;
    logic                   write;
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;
    logic [CW-1:0]          count;
    logic [Flit_size-1:0]   mem [Depth];

    assign flit_type = flit_type_t'(In_data[Flit_size-1:Flit_size-2]);
    assign Full      = (count == CW'(Depth));
    assign Out_valid = (count != '0);
    assign pop       = Out_valid && Out_ready;
    assign space_ok  = !Full || pop;
    assign write     = In_valid && fsm_accept && space_ok;
    assign Credit    = CW'(Depth) - count;
    assign Port_busy = (state_q == PKT);
    // Masking keeps stale memory contents off the bus when the FIFO is empty.
    assign Out_data  = Out_valid ? mem[rd_ptr] : '0;

    always_comb begin
        state_d    = state_q;
        fsm_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (flit_type == FT_HEAD) begin
                    fsm_accept = 1'b1;
                    state_d    = PKT;
                end else if (flit_type == FT_SINGLE) begin
                    fsm_accept = 1'b1;
                end
            end
            PKT: begin
                if (flit_type == FT_BODY) begin
                    fsm_accept = 1'b1;
                end else if (flit_type == FT_TAIL) begin
                    fsm_accept = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The FSM only advances on an actual write, so overflow drops leave it alone.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else if (write) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (write) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            case ({write, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && write) begin
            mem[wr_ptr] <= In_data;
        end
    end

    // Both error flags are sticky until reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Ovf_err   <= 1'b0;
            Proto_err <= 1'b0;
        end else begin
            if (In_valid && !space_ok)   Ovf_err   <= 1'b1;
            if (In_valid && !fsm_accept) Proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_out_port_buffer.sv
// Bench for out_port_buffer: directed scenarios then random traffic, checked
// each cycle against a queue-based packet/FIFO model.
module tb_out_port_buffer;

    localparam int FS    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [FS-1:0] In_data = '0;
    logic          In_valid = 1'b0;
    logic [FS-1:0] Out_data;
    logic          Out_valid;
    logic          Out_ready = 1'b0;
    logic [CW-1:0] Credit;
    logic          Full;
    logic          Port_busy;
    logic          Ovf_err;
    logic          Proto_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [FS-1:0] exp_q[$];
    bit            m_open;
    bit            m_ovf;
    bit            m_proto;

    out_port_buffer #(.Flit_size(FS), .Depth(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .In_data   (In_data),
        .In_valid  (In_valid),
        .Out_data  (Out_data),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Credit    (Credit),
        .Full      (Full),
        .Port_busy (Port_busy),
        .Ovf_err   (Ovf_err),
        .Proto_err (Proto_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit v, input logic [FS-1:0] d, input bit rdy);
        int  n;
        bit  pop, full, ok;
        logic [1:0] t;
        n    = exp_q.size();
        pop  = (n != 0) && rdy;
        full = (n == DEPTH);
        if (rst) begin
            exp_q.delete();
            m_open  = 0;
            m_ovf   = 0;
            m_proto = 0;
            return;
        end
        if (pop) void'(exp_q.pop_front());
        if (v) begin
            t  = d[FS-1:FS-2];
            ok = m_open ? (t == 2'b01 || t == 2'b10) : (t == 2'b00 || t == 2'b11);
            if (!ok) m_proto = 1;
            if (full && !pop) m_ovf = 1;
            if (ok && !(full && !pop)) begin
                exp_q.push_back(d);
                if (t == 2'b00) m_open = 1;
                if (t == 2'b10) m_open = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [FS-1:0] ed;
        ed = (exp_q.size() != 0) ? exp_q[0] : '0;
        chk("out_valid", 32'(Out_valid), 32'(exp_q.size() != 0));
        chk("out_data",  32'(Out_data),  32'(ed));
        chk("credit",    32'(Credit),    32'(DEPTH - exp_q.size()));
        chk("full",      32'(Full),      32'(exp_q.size() == DEPTH));
        chk("port_busy", 32'(Port_busy), 32'(m_open));
        chk("ovf_err",   32'(Ovf_err),   32'(m_ovf));
        chk("proto_err", 32'(Proto_err), 32'(m_proto));
    endtask

    // One clock: drive inputs, take the edge, settle, compare everything.
    task automatic step(input bit rst, input bit v, input logic [FS-1:0] d, input bit rdy);
        RST       = rst;
        In_valid  = v;
        In_data   = d;
        Out_ready = rdy;
        model_edge(rst, v, d, rdy);
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        RST = 1'b0;
    endtask

    initial begin
        logic [FS-1:0] f;
        int            r;
        #1;
        // Reset state
        do_reset();
        chk("reset_credit", 32'(Credit), 32'(DEPTH));

        // Three-flit packet streaming through with Out_ready held high
        step(0, 1, 16'h0011, 1);
        chk("busy_after_head", 32'(Port_busy), 32'd1);
        chk("credit_ge3", 32'(Credit >= 3), 32'd1);
        step(0, 1, 16'h4022, 1);
        chk("credit_ge3", 32'(Credit >= 3), 32'd1);
        step(0, 1, 16'h8033, 1);
        chk("busy_after_tail", 32'(Port_busy), 32'd0);
        chk("data_tail", 32'(Out_data), 32'h8033);
        step(0, 0, '0, 1);

        // Fill with back-pressure, overflow, then simultaneous push/pop when full
        step(0, 1, 16'h0101, 0);
        step(0, 1, 16'h4102, 0);
        step(0, 1, 16'h4103, 0);
        step(0, 1, 16'h4104, 0);
        chk("full_set", 32'(Full), 32'd1);
        step(0, 1, 16'h4105, 0);
        chk("ovf_set", 32'(Ovf_err), 32'd1);
        chk("head_kept", 32'(Out_data), 32'h0101);
        do_reset();
        step(0, 1, 16'h0201, 0);
        step(0, 1, 16'h4202, 0);
        step(0, 1, 16'h4203, 0);
        step(0, 1, 16'h4204, 0);
        step(0, 1, 16'h4205, 1);
        chk("push_pop_full_credit", 32'(Credit), 32'd0);
        chk("push_pop_full_noovf", 32'(Ovf_err), 32'd0);
        step(0, 1, 16'h8206, 1);
        for (int i = 0; i < 5; i++) step(0, 0, '0, 1);

        // Protocol violation in IDLE, then a single-flit packet
        do_reset();
        step(0, 1, 16'h4055, 1);
        chk("proto_body_idle", 32'(Proto_err), 32'd1);
        step(0, 1, 16'hC066, 0);
        chk("single_stored", 32'(Out_data), 32'hC066);
        step(0, 0, '0, 1);

        // Six flits through a four-entry FIFO so both pointers wrap
        do_reset();
        step(0, 1, 16'h0301, 0);
        step(0, 1, 16'h4302, 0);
        step(0, 1, 16'h4303, 0);
        step(0, 1, 16'h4304, 0);
        step(0, 1, 16'h4305, 1);
        step(0, 1, 16'h8306, 1);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1);
        chk("wrap_credit", 32'(Credit), 32'(DEPTH));

        // Reset while a packet is open with two entries held
        step(0, 1, 16'h0401, 0);
        step(0, 1, 16'h4402, 0);
        step(0, 1, 16'h0000, 0);
        do_reset();
        chk("rst_mid_busy", 32'(Port_busy), 32'd0);
        step(0, 1, 16'h0501, 0);
        chk("head_after_rst", 32'(Out_data), 32'h0501);

        // Random traffic, mostly well-formed with occasional violations
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            f = FS'($urandom);
            if (r < 85) begin
                if (m_open) f[FS-1:FS-2] = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b01;
                else        f[FS-1:FS-2] = ($urandom_range(0, 2) == 0) ? 2'b11 : 2'b00;
            end
            if (i == 200) do_reset();
            step(0, ($urandom_range(0, 2) != 0), f, ($urandom_range(0, 1) == 1));
        end
        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, '0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
